// File: rtl/cordic_vectoring.sv
// Iterative vectoring-mode CORDIC: (x, y) -> atan2(y, x) and magnitude.
// Optional gain compensation stage enabled by `CORDIC_GAIN_COMP_EN.
module cordic_vectoring #(
  parameter int INTEGER_WIDTH    = 4,
  parameter int FRACTIONAL_WIDTH = 20,
  parameter int DATA_WIDTH       = INTEGER_WIDTH + FRACTIONAL_WIDTH,
  parameter int ITERATIONS       = 16,
  parameter int COUNTER_WIDTH    = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] x_in,
  input  logic [DATA_WIDTH-1:0] y_in,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] angle_out,
  output logic [DATA_WIDTH+1:0] mag_out
);

  localparam int XW = DATA_WIDTH + 2;
  localparam logic [COUNTER_WIDTH-1:0] LAST = COUNTER_WIDTH'(ITERATIONS - 1);
  localparam logic signed [DATA_WIDTH-1:0] PI = DATA_WIDTH'(24'sh3243F7);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
`ifdef CORDIC_GAIN_COMP_EN
    GAIN,
`endif
    DONE
  } state_t;

  state_t                   state;
  logic signed [XW-1:0]     x, y, x_shr, y_shr, x_next, y_next, x_ext, y_ext;
  logic signed [DATA_WIDTH-1:0] z, z_next;
  logic [COUNTER_WIDTH-1:0] i;

  function automatic logic signed [DATA_WIDTH-1:0] atan_lut(input logic [COUNTER_WIDTH-1:0] idx);
    logic signed [DATA_WIDTH-1:0] v;
    case (int'(idx))
      0:       v = DATA_WIDTH'(24'h0C90FE);
      1:       v = DATA_WIDTH'(24'h076B1A);
      2:       v = DATA_WIDTH'(24'h03EB6F);
      3:       v = DATA_WIDTH'(24'h01FD5C);
      4:       v = DATA_WIDTH'(24'h00FFAB);
      5:       v = DATA_WIDTH'(24'h007FF5);
      6:       v = DATA_WIDTH'(24'h003FFF);
      7:       v = DATA_WIDTH'(24'h002000);
      8:       v = DATA_WIDTH'(24'h001000);
      9:       v = DATA_WIDTH'(24'h000800);
      10:      v = DATA_WIDTH'(24'h000400);
      11:      v = DATA_WIDTH'(24'h000200);
      12:      v = DATA_WIDTH'(24'h000100);
      13:      v = DATA_WIDTH'(24'h000080);
      14:      v = DATA_WIDTH'(24'h000040);
      15:      v = DATA_WIDTH'(24'h000020);
      default: v = '0;
    endcase
    return v;
  endfunction

  // Two guard bits let -8.0 be negated and absorb the ~1.65 CORDIC gain.
  assign x_ext = {{2{x_in[DATA_WIDTH-1]}}, x_in};
  assign y_ext = {{2{y_in[DATA_WIDTH-1]}}, y_in};

  always_comb begin
    x_shr = x >>> i;
    y_shr = y >>> i;
    if (!y[XW-1]) begin
      x_next = x + y_shr;
      y_next = y - x_shr;
      z_next = z + atan_lut(i);
    end else begin
      x_next = x - y_shr;
      y_next = y + x_shr;
      z_next = z - atan_lut(i);
    end
  end

`ifdef CORDIC_GAIN_COMP_EN
  localparam int KW = 20;
  localparam logic signed [KW:0] K = 21'sh09B750;
  logic signed [XW+KW-1:0] prod;

  always_comb prod = x * K;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      angle_out <= '0;
      mag_out   <= '0;
      x         <= '0;
      y         <= '0;
      z         <= '0;
      i         <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            // Left half-plane: rotate by pi so the iterations only cover +-pi/2.
            if (x_in[DATA_WIDTH-1]) begin
              x <= -x_ext;
              y <= -y_ext;
              z <= y_in[DATA_WIDTH-1] ? -PI : PI;
            end else begin
              x <= x_ext;
              y <= y_ext;
              z <= '0;
            end
            i     <= '0;
            busy  <= 1'b1;
            state <= ITER;
          end
        end
        ITER: begin
          x <= x_next;
          y <= y_next;
          z <= z_next;
          i <= i + 1'b1;
          if (i == LAST) begin
`ifdef CORDIC_GAIN_COMP_EN
            state <= GAIN;
`else
            mag_out   <= x_next;
            angle_out <= z_next;
            done      <= 1'b1;
            state     <= DONE;
`endif
          end
        end
`ifdef CORDIC_GAIN_COMP_EN
        GAIN: begin
          mag_out   <= XW'(prod >>> KW);
          angle_out <= z;
          done      <= 1'b1;
          state     <= DONE;
        end
`endif
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/cordic_vectoring.md
# cordic_vectoring

Iterative vectoring-mode CORDIC. Takes a signed fixed-point vector (x, y) and returns its angle atan2(y, x) and its magnitude. It is the inverse of the rotation-mode CORDIC used for cosine: rotation turns an angle into coordinates, this block turns coordinates back into an angle and radius. It sits in the fixed-point domain, downstream of the float-to-fixed converter and upstream of the fixed-to-float converter.

## Interface
- `INTEGER_WIDTH`, default 4: integer bits of the signed input/angle format, sign included.
- `FRACTIONAL_WIDTH`, default 20: fractional bits.
- `DATA_WIDTH`, default `INTEGER_WIDTH+FRACTIONAL_WIDTH` (24): input and angle width.
- `ITERATIONS`, default 16: number of micro-rotations, range 1..16.
- `COUNTER_WIDTH`, default 5: iteration counter width.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: request; sampled only in IDLE.
- `x_in` in `DATA_WIDTH`: signed x, Q4.20.
- `y_in` in `DATA_WIDTH`: signed y, Q4.20.
- `busy` out 1: high whenever state is not IDLE.
- `done` out 1: one-cycle pulse; results are valid.
- `angle_out` out `DATA_WIDTH`: signed angle in radians, Q4.20, range (-π, π].
- `mag_out` out `DATA_WIDTH+2`: unsigned magnitude, Q6.20.

## Operation
- States are IDLE, ITER, GAIN (present only with the macro), DONE.
- **Reset:** state is IDLE.
  - `busy`, `done`, `angle_out`, `mag_out` are all 0.
  - x, y, z and the counter are all 0.
- **Internal datapath:**
  - x and y are held at `DATA_WIDTH+2` bits, sign-extended, which gives guard bits for the gain growth of 1.6468 and for negating -8.0.
  - z is held at `DATA_WIDTH` bits.
- **IDLE with `start`=1 (capture and quadrant fold):**
  - If x_in < 0: x = -x_in, y = -y_in, and z = +π (0x3243F7) when y_in ≥ 0, otherwise z = -π.
  - Otherwise: x = x_in, y = y_in, z = 0.
  - Counter i = 0, then go to ITER.
- **ITER (one micro-rotation per cycle):**
  - If y ≥ 0: x += y>>>i, y -= x>>>i, z += atan_lut[i].
  - Else: x -= y>>>i, y += x>>>i, z -= atan_lut[i].
  - Both updates use the old x and y. Shifts are arithmetic.
  - `atan_lut[i]` = round(atan(2^-i)·2^20); it is a constant ROM of 16 entries, entry 0 = 0x0C90FE.
  - i increments each cycle. On the iteration with i = `ITERATIONS-1`, go to GAIN if the macro is defined, otherwise register the outputs and go to DONE.
- **GAIN:**
  - `mag_out` = (x · K) >>> 20, where K = 0x9B750 (0.6072529 in Q0.20). The product is truncated toward -∞.
  - `angle_out` = z; then go to DONE.
- **DONE:**
  - `done` = 1 for exactly this cycle, then return to IDLE.
  - `angle_out` and `mag_out` hold until the next completion or reset.
- **Angle wrap:** z is not wrapped. The fold keeps |z| ≤ π + 1.75, which fits Q4.20.
- **Boundary cases:**
  - (0,0) gives `angle_out` = result of the iteration (any value) and `mag_out` = 0; the bench checks only `mag_out`.
  - x_in = -8.0 negates correctly thanks to the guard bits.
  - `start` while `busy` is ignored; there is no queueing and the inputs are not resampled.
  - `rst` in any state returns to IDLE on the next edge and clears the outputs. `done` is never asserted for an aborted operation.

## Timing
- `start` is high in cycle 0. ITER occupies cycles 1..`ITERATIONS`.
- With the macro: GAIN is in cycle N+1 and `done` is high in cycle N+2 (latency 18 for N=16).
- Without the macro: the outputs are written at the end of cycle N and `done` is high in cycle N+1 (latency 17).
- `busy` rises in cycle 1 and falls in the cycle after `done`.
- The earliest next accepted `start` is in the cycle after `done`.
- Throughput is one result per N+3 cycles (with the macro) or N+2 cycles (without).

## Configuration
- Macro: `CORDIC_GAIN_COMP_EN`.
  - **Defined:** the GAIN state and a `DATA_WIDTH+2` × 20 constant multiplier are present, `mag_out` is the true magnitude, and latency is N+2.
  - **Undefined:** there is no multiplier and no GAIN state. `mag_out` is the raw x, i.e. magnitude × An, where An = 1.6468 for N=16; the downstream stage removes the gain. Latency is N+1.
- `angle_out` is identical in both builds.

## Test plan
All cases use the defaults and the macro defined; tolerances are ±64 LSB.
- (1.0, 0) = (0x100000, 0) → `angle_out` 0, `mag_out` 0x100000, `done` in cycle 18.
- (0, 1.0) → `angle_out` 0x1921FB (π/2), `mag_out` 0x100000.
- (-1.0, 0) → `angle_out` 0x3243F7 (π); (-1.0, -1.0) → `angle_out` -0x25B2F9 (-3π/4), `mag_out` 0x16A09E (√2).
- (-8.0, 0) → `angle_out` π, `mag_out` 0x800000, with no overflow. (0,0) → `mag_out` 0.
- `start` pulsed again in cycle 5 with different inputs → ignored; the first result is unchanged and exactly one `done` is seen.
- `rst` asserted in cycle 8 → IDLE with all outputs 0 at the next edge and no `done`. A new `start` afterwards completes normally.
